m62_rom_loader: RTL and testbench
=================================

Name: m62_rom_loader

Overview:
- Sits between the HPS ioctl download stream and the memory consumers: SDRAM port1/port2 write queues, the sound-ROM dpram, the colour/height PROM loader, the core-mod and DIP registers.
- Decodes each downloaded byte by index and address, then issues the SDRAM write as a req/ack toggle handshake through a one-deep pending buffer per port.
- Also generates `rom_loaded` and the stretched core reset consumed by `target_top`.

Parameters:
- RESET_CYCLES, 16'hFFFF, core reset stretch length in clk_sys cycles after the last reset cause.
- SP_BASE, 25'h30000, first address routed to port2; port2 address = ioctl_addr - SP_BASE.
- PROM_BASE, 25'hA0000, first address routed to the PROM write port.
- PROM_SIZE, 12'h920, number of PROM bytes (A0000-A091F).

Ports:
- clk_sys in 1: system clock; all logic on its rising edge.
- reset in 1: synchronous, active-high; clears all state except `core_mod` and `sw`.
- ioctl_download in 1: download active.
- ioctl_index in 8: 0 = ROM, 1 = core mod, 254 = DIP.
- ioctl_wr in 1: byte strobe.
- ioctl_addr in 25: byte address.
- ioctl_dout in 8: byte data.
- status_reset in 1: OSD reset (status[0] | buttons[1]).
- port1_ack in 1: SDRAM port1 ack toggle.
- port2_ack in 1: SDRAM port2 ack toggle.
- port1_req out 1: toggle request.
- port1_a out 23: word address.
- port1_ds out 2: byte strobes {a[0], ~a[0]}.
- port1_d out 16: {byte, byte}.
- port2_req out 1 / port2_a out 23 / port2_ds out 2 / port2_d out 16: same as port1, computed on the offset address.
- snd_we out 1 / snd_addr out 16 / snd_data out 8: sound dpram write.
- prom_we out 1 / prom_addr out 12 / prom_data out 8: PROM write.
- core_mod out 8: hardware variant.
- sw0 out 8, sw1 out 8: DIP bytes 0/1.
- rom_loaded out 1: at least one complete ROM download seen.
- core_reset out 1: stretched reset to the core.
- overrun out 1: sticky, a byte was dropped.

Behaviour:
- Reset values: req/a/ds/d = 0; snd_we = prom_we = 0; rom_loaded = 0; core_reset = 1; overrun = 0; pending buffers empty. `core_mod` and `sw` are 0 only at power-up and are not cleared by `reset`.
- Accept: `acc` = ioctl_wr & ~ioctl_wr_d (rising-edge detect, registered). Each byte is processed exactly once however long the strobe is held.
- Index 0 routing when `acc` (a byte may match several targets):
  - addr < PROM_BASE → port1.
  - SP_BASE ≤ addr < PROM_BASE → also port2.
  - 20000 ≤ addr < 30000 → also snd.
  - PROM_BASE ≤ addr < PROM_BASE + PROM_SIZE → prom only.
  - All other addresses are ignored.
- snd/prom writes: `*_we` pulses high for exactly 1 cycle, on the cycle after `acc`. Address and data are registered with it; snd_addr = addr[15:0], prom_addr = addr - PROM_BASE.
- Per SDRAM port FSM, where busy = req ^ ack:
  - IDLE: on a routed byte, register a/ds/d and toggle req the next cycle; go to WAIT.
  - WAIT, new routed byte: if the pending buffer is empty, store it; if full, set `overrun` and drop the byte.
  - WAIT, ack toggle (busy = 0): if pending is valid, issue it the next cycle, clear pending and stay in WAIT; else go to IDLE.
  - Simultaneous ack and new byte with pending empty: issue the new byte directly; pending stays empty.
- Index 1 `acc`: core_mod <= dout; the last byte wins.
- Index 254 `acc` with addr[24:3] == 0: addr 0 → sw0, addr 1 → sw1; addr 2..7 are accepted and discarded.
- rom_loaded: set on the cycle after the falling edge of (ioctl_download & index == 0). Never cleared except by `reset`.
- Reset counter (16 bit):
  - Reload to RESET_CYCLES while status_reset | ~rom_loaded | (ioctl_download & index == 0).
  - Otherwise decrement to 0 and hold.
  - core_reset = (count != 0), registered.
- `reset` mid-transfer: the FSMs return to IDLE, req returns to 0 and pending is discarded. The SDRAM ack must also be reset, so that req ^ ack = 0 afterwards.
- Writes are ignored while ioctl_download = 0.

Test Plan:
- Index 0, bytes at 00000, 00001 with ack returned 4 cycles after each req → port1_req toggles twice; port1_a = 0 both times; port1_ds = 01 then 10; port2_req does not toggle.
- Byte 5A at 25000 → snd_we single pulse, snd_addr = 5000, snd_data = 5A; port1 write to word 12800; no port2 write.
- Byte at 30003 → port2_a = 1, ds = 10; port1_a = 18001. Byte at A0905 → prom_we, prom_addr = 905, no SDRAM writes; byte at A0920 → ignored.
- Three accepted bytes back-to-back with ack withheld → first is issued, second is pending, third sets overrun = 1. Releasing ack issues the second byte one cycle later.
- Index 254: addr 0 = 0x3C, addr 1 = 0xF0, addr 8 = 0x11 → sw0 = 3C, sw1 = F0, unchanged by addr 8. Index 1: byte 0B → core_mod = 0B.
- ROM download ends → rom_loaded = 1; core_reset falls exactly RESET_CYCLES + 1 cycles later. status_reset pulsed mid-count → core_reset stays high a full RESET_CYCLES from the pulse.

Source files
------------

// File: rtl/m62_rom_loader_if.sv
// ioctl download stream and the two SDRAM write request ports of the M62 ROM loader.
// The master side is the HPS/SDRAM environment; the loader connects as slave.
interface m62_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;

  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output port1_ack, port2_ack,
    input  port1_req, port1_a, port1_ds, port1_d,
    input  port2_req, port2_a, port2_ds, port2_d
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  port1_ack, port2_ack,
    output port1_req, port1_a, port1_ds, port1_d,
    output port2_req, port2_a, port2_ds, port2_d
  );
endinterface

// File: rtl/m62_rom_loader.sv
// M62 ROM loader: routes ioctl download bytes to SDRAM ports, sound dpram, PROMs,
// core-mod and DIP registers, and generates rom_loaded and the stretched core reset.
module m62_rom_loader #(
  parameter logic [15:0] RESET_CYCLES = 16'hFFFF,
  parameter logic [24:0] SP_BASE      = 25'h30000,
  parameter logic [24:0] PROM_BASE    = 25'hA0000,
  parameter logic [11:0] PROM_SIZE    = 12'h920
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    status_reset,
  m62_rom_loader_if.slave         bus,
  output logic                    snd_we,
  output logic [15:0]             snd_addr,
  output logic [7:0]              snd_data,
  output logic                    prom_we,
  output logic [11:0]             prom_addr,
  output logic [7:0]              prom_data,
  output logic [7:0]              core_mod,
  output logic [7:0]              sw0,
  output logic [7:0]              sw1,
  output logic                    rom_loaded,
  output logic                    core_reset,
  output logic                    overrun
);

  localparam logic [24:0] SND_BASE = 25'h20000;
  localparam logic [24:0] SND_END  = 25'h30000;
  localparam logic [24:0] PROM_END = PROM_BASE + 25'(PROM_SIZE);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  // Byte capture stage
  logic        wr_d_q, wr_d_d;
  logic        acc_q, acc_d;
  logic [7:0]  idx_q, idx_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;

  // SDRAM port state, index 0 = port1, 1 = port2
  state_e      state_q [2];
  state_e      state_d [2];
  logic [1:0]  req_q, req_d;
  logic [1:0]  pend_q, pend_d;
  logic [22:0] a_q [2];
  logic [22:0] a_d [2];
  logic [1:0]  ds_q [2];
  logic [1:0]  ds_d [2];
  logic [15:0] d_q [2];
  logic [15:0] d_d [2];
  logic [22:0] pa_q [2];
  logic [22:0] pa_d [2];
  logic [1:0]  pds_q [2];
  logic [1:0]  pds_d [2];
  logic [15:0] pd_q [2];
  logic [15:0] pd_d [2];

  logic        snd_we_q, snd_we_d;
  logic [15:0] snd_addr_q, snd_addr_d;
  logic [7:0]  snd_data_q, snd_data_d;
  logic        prom_we_q, prom_we_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;
  logic        overrun_q, overrun_d;
  logic        rom_dl_q, rom_dl_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic [15:0] cnt_q, cnt_d;
  logic        core_reset_q, core_reset_d;

  // Power-up only; these survive the core reset
  logic [7:0]  core_mod_q = '0;
  logic [7:0]  sw0_q = '0;
  logic [7:0]  sw1_q = '0;
  logic [7:0]  core_mod_d, sw0_d, sw1_d;

  logic        rom_byte, snd_hit, prom_hit, rom_dl;
  logic [1:0]  hit, ack, busy;
  logic [23:0] sp_off;
  logic [11:0] prom_off;
  logic [22:0] wa [2];
  logic [1:0]  wds [2];

  assign rom_dl   = bus.ioctl_download & (bus.ioctl_index == 8'd0);
  assign rom_byte = acc_q & (idx_q == 8'd0);
  assign sp_off   = addr_q[23:0] - SP_BASE[23:0];
  assign prom_off = addr_q[11:0] - PROM_BASE[11:0];

  assign hit[0]   = rom_byte & (addr_q < PROM_BASE);
  assign hit[1]   = rom_byte & (addr_q >= SP_BASE) & (addr_q < PROM_BASE);
  assign snd_hit  = rom_byte & (addr_q >= SND_BASE) & (addr_q < SND_END);
  assign prom_hit = rom_byte & (addr_q >= PROM_BASE) & (addr_q < PROM_END);

  assign wa[0]  = addr_q[23:1];
  assign wds[0] = {addr_q[0], ~addr_q[0]};
  assign wa[1]  = sp_off[23:1];
  assign wds[1] = {sp_off[0], ~sp_off[0]};

  assign ack  = {bus.port2_ack, bus.port1_ack};
  assign busy = req_q ^ ack;

  always_comb begin
    wr_d_d       = bus.ioctl_wr;
    acc_d        = bus.ioctl_wr & ~wr_d_q & bus.ioctl_download;
    idx_d        = bus.ioctl_index;
    addr_d       = bus.ioctl_addr;
    dout_d       = bus.ioctl_dout;
    state_d      = state_q;
    req_d        = req_q;
    pend_d       = pend_q;
    a_d          = a_q;
    ds_d         = ds_q;
    d_d          = d_q;
    pa_d         = pa_q;
    pds_d        = pds_q;
    pd_d         = pd_q;
    overrun_d    = overrun_q;
    snd_we_d     = snd_hit;
    snd_addr_d   = snd_addr_q;
    snd_data_d   = snd_data_q;
    prom_we_d    = prom_hit;
    prom_addr_d  = prom_addr_q;
    prom_data_d  = prom_data_q;
    core_mod_d   = core_mod_q;
    sw0_d        = sw0_q;
    sw1_d        = sw1_q;
    rom_dl_d     = rom_dl;
    rom_loaded_d = rom_loaded_q | (rom_dl_q & ~rom_dl);
    cnt_d        = cnt_q;
    core_reset_d = (cnt_q != '0);

    for (int unsigned p = 0; p < 2; p++) begin
      case (state_q[p])
        S_IDLE: begin
          if (hit[p]) begin
            a_d[p]     = wa[p];
            ds_d[p]    = wds[p];
            d_d[p]     = {dout_q, dout_q};
            req_d[p]   = ~req_q[p];
            state_d[p] = S_WAIT;
          end
        end
        default: begin
          if (!busy[p]) begin
            // Acked: pending goes out first and a same-cycle byte takes its slot
            if (pend_q[p]) begin
              a_d[p]    = pa_q[p];
              ds_d[p]   = pds_q[p];
              d_d[p]    = pd_q[p];
              req_d[p]  = ~req_q[p];
              pend_d[p] = hit[p];
              if (hit[p]) begin
                pa_d[p]  = wa[p];
                pds_d[p] = wds[p];
                pd_d[p]  = {dout_q, dout_q};
              end
            end else if (hit[p]) begin
              a_d[p]   = wa[p];
              ds_d[p]  = wds[p];
              d_d[p]   = {dout_q, dout_q};
              req_d[p] = ~req_q[p];
            end else begin
              state_d[p] = S_IDLE;
            end
          end else if (hit[p]) begin
            if (!pend_q[p]) begin
              pend_d[p] = 1'b1;
              pa_d[p]   = wa[p];
              pds_d[p]  = wds[p];
              pd_d[p]   = {dout_q, dout_q};
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      endcase
    end

    if (snd_hit) begin
      snd_addr_d = addr_q[15:0];
      snd_data_d = dout_q;
    end
    if (prom_hit) begin
      prom_addr_d = prom_off;
      prom_data_d = dout_q;
    end

    if (acc_q && idx_q == 8'd1) core_mod_d = dout_q;
    if (acc_q && idx_q == 8'd254 && addr_q[24:3] == '0) begin
      if (addr_q[2:0] == 3'd0) sw0_d = dout_q;
      if (addr_q[2:0] == 3'd1) sw1_d = dout_q;
    end

    if (status_reset || !rom_loaded_q || rom_dl) cnt_d = RESET_CYCLES;
    else if (cnt_q != '0)                        cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_d_q       <= 1'b0;
      acc_q        <= 1'b0;
      idx_q        <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      req_q        <= '0;
      pend_q       <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        state_q[p] <= S_IDLE;
        a_q[p]     <= '0;
        ds_q[p]    <= '0;
        d_q[p]     <= '0;
        pa_q[p]    <= '0;
        pds_q[p]   <= '0;
        pd_q[p]    <= '0;
      end
      overrun_q    <= 1'b0;
      snd_we_q     <= 1'b0;
      snd_addr_q   <= '0;
      snd_data_q   <= '0;
      prom_we_q    <= 1'b0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
      rom_dl_q     <= 1'b0;
      rom_loaded_q <= 1'b0;
      cnt_q        <= RESET_CYCLES;
      core_reset_q <= 1'b1;
    end else begin
      wr_d_q       <= wr_d_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      req_q        <= req_d;
      pend_q       <= pend_d;
      state_q      <= state_d;
      a_q          <= a_d;
      ds_q         <= ds_d;
      d_q          <= d_d;
      pa_q         <= pa_d;
      pds_q        <= pds_d;
      pd_q         <= pd_d;
      overrun_q    <= overrun_d;
      snd_we_q     <= snd_we_d;
      snd_addr_q   <= snd_addr_d;
      snd_data_q   <= snd_data_d;
      prom_we_q    <= prom_we_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      rom_dl_q     <= rom_dl_d;
      rom_loaded_q <= rom_loaded_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    core_mod_q <= core_mod_d;
    sw0_q      <= sw0_d;
    sw1_q      <= sw1_d;
  end

  assign bus.port1_req = req_q[0];
  assign bus.port1_a   = a_q[0];
  assign bus.port1_ds  = ds_q[0];
  assign bus.port1_d   = d_q[0];
  assign bus.port2_req = req_q[1];
  assign bus.port2_a   = a_q[1];
  assign bus.port2_ds  = ds_q[1];
  assign bus.port2_d   = d_q[1];

  assign snd_we     = snd_we_q;
  assign snd_addr   = snd_addr_q;
  assign snd_data   = snd_data_q;
  assign prom_we    = prom_we_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign core_mod   = core_mod_q;
  assign sw0        = sw0_q;
  assign sw1        = sw1_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_m62_rom_loader.sv
// Scoreboard bench for m62_rom_loader: stimulus pushes expected writes, a monitor
// pops them as the loader issues SDRAM/snd/PROM writes.
module tb_m62_rom_loader;
  localparam logic [15:0] RC = 16'd20;

  logic clk = 1'b0;
  logic reset, status_reset;
  logic snd_we, prom_we, rom_loaded, core_reset, overrun;
  logic [15:0] snd_addr;
  logic [11:0] prom_addr;
  logic [7:0]  snd_data, prom_data, core_mod, sw0, sw1;

  int errors = 0;
  int checks = 0;

  logic [40:0] q1[$];
  logic [40:0] q2[$];
  logic [23:0] qs[$];
  logic [19:0] qp[$];
  logic [1:0]  hold = '0;
  logic [2:0]  cnt1 = '0, cnt2 = '0;

  m62_rom_loader_if bus();

  m62_rom_loader #(.RESET_CYCLES(RC)) dut (
    .clk_sys(clk), .reset(reset), .status_reset(status_reset), .bus(bus),
    .snd_we(snd_we), .snd_addr(snd_addr), .snd_data(snd_data),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .core_mod(core_mod), .sw0(sw0), .sw1(sw1),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected write expected none", name);
  endtask

  function automatic logic [40:0] pk(input logic [22:0] a, input logic [1:0] ds, input logic [7:0] b);
    return {a, ds, b, b};
  endfunction

  // SDRAM model: acks 4 cycles after each request toggle unless held
  always @(posedge clk) begin
    if (reset) begin
      bus.port1_ack <= 1'b0; bus.port2_ack <= 1'b0; cnt1 <= '0; cnt2 <= '0;
    end else begin
      if (bus.port1_req != bus.port1_ack && !hold[0]) begin
        if (cnt1 == 3'd3) begin bus.port1_ack <= bus.port1_req; cnt1 <= '0; end
        else cnt1 <= cnt1 + 3'd1;
      end else cnt1 <= '0;
      if (bus.port2_req != bus.port2_ack && !hold[1]) begin
        if (cnt2 == 3'd3) begin bus.port2_ack <= bus.port2_req; cnt2 <= '0; end
        else cnt2 <= cnt2 + 3'd1;
      end else cnt2 <= '0;
    end
  end

  // Monitor
  initial begin : monitor
    logic p1, p2, ps, pp;
    logic [40:0] e41;
    logic [23:0] e24;
    logic [19:0] e20;
    p1 = 1'b0; p2 = 1'b0; ps = 1'b0; pp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p1 = bus.port1_req; p2 = bus.port2_req; ps = 1'b0; pp = 1'b0;
      end else begin
        if (bus.port1_req != p1) begin
          if (q1.size() == 0) unexpected("port1_write");
          else begin e41 = q1.pop_front(); check("port1_write", {bus.port1_a, bus.port1_ds, bus.port1_d}, e41); end
        end
        if (bus.port2_req != p2) begin
          if (q2.size() == 0) unexpected("port2_write");
          else begin e41 = q2.pop_front(); check("port2_write", {bus.port2_a, bus.port2_ds, bus.port2_d}, e41); end
        end
        if (snd_we) begin
          check("snd_we_single", ps, 1'b0);
          if (qs.size() == 0) unexpected("snd_write");
          else begin e24 = qs.pop_front(); check("snd_write", {snd_addr, snd_data}, e24); end
        end
        if (prom_we) begin
          check("prom_we_single", pp, 1'b0);
          if (qp.size() == 0) unexpected("prom_write");
          else begin e20 = qp.pop_front(); check("prom_write", {prom_addr, prom_data}, e20); end
        end
        p1 = bus.port1_req; p2 = bus.port2_req; ps = snd_we; pp = prom_we;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [24:0] addr, input logic [7:0] data, input int gap);
    @(negedge clk);
    bus.ioctl_addr = addr; bus.ioctl_dout = data; bus.ioctl_wr = 1'b1;
    repeat (2) @(negedge clk);
    bus.ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic measure_fall(input string name);
    int n;
    n = 0;
    while (core_reset && n < 200) begin @(negedge clk); n++; end
    check(name, 64'(n), 64'(RC) + 64'd1);
  endtask

  initial begin : stim
    int n;
    logic a0;
    reset = 1'b1; status_reset = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_index = '0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_rom_loaded", rom_loaded, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_reqs", {bus.port1_req, bus.port2_req}, 2'b00);
    check("powerup_core_mod", core_mod, 8'h00);

    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0;
    q1.push_back(pk(23'h0, 2'b01, 8'hA1)); send(25'h00000, 8'hA1, 8);
    q1.push_back(pk(23'h0, 2'b10, 8'hB2)); send(25'h00001, 8'hB2, 8);
    qs.push_back({16'h5000, 8'h5A}); q1.push_back(pk(23'h12800, 2'b01, 8'h5A));
    send(25'h25000, 8'h5A, 8);
    q1.push_back(pk(23'h18001, 2'b10, 8'h77)); q2.push_back(pk(23'h1, 2'b10, 8'h77));
    send(25'h30003, 8'h77, 8);
    qp.push_back({12'h905, 8'h9C}); send(25'hA0905, 8'h9C, 8);
    send(25'hA0920, 8'hEE, 8);

    // Overrun: ack withheld, third byte dropped
    hold[0] = 1'b1;
    q1.push_back(pk(23'h80, 2'b01, 8'h11)); send(25'h00100, 8'h11, 1);
    q1.push_back(pk(23'h81, 2'b01, 8'h22)); send(25'h00102, 8'h22, 1);
    send(25'h00104, 8'h33, 3);
    check("overrun_set", overrun, 1'b1);
    a0 = bus.port1_ack;
    hold[0] = 1'b0;
    n = 0;
    while (bus.port1_ack == a0 && n < 20) begin @(negedge clk); n++; end
    check("ack_seen", 64'(n < 20), 64'd1);
    @(negedge clk);
    check("pending_issued_next", bus.port1_req ^ bus.port1_ack, 1'b1);
    repeat (10) @(negedge clk);

    // ROM download ends
    bus.ioctl_download = 1'b0;
    n = 0;
    while (!rom_loaded && n < 10) begin @(negedge clk); n++; end
    check("rom_loaded", rom_loaded, 1'b1);
    measure_fall("core_reset_after_load");

    @(negedge clk); status_reset = 1'b1; @(negedge clk); status_reset = 1'b0;
    repeat (8) @(negedge clk);
    check("core_reset_restart", core_reset, 1'b1);
    status_reset = 1'b1; @(negedge clk); status_reset = 1'b0;
    measure_fall("core_reset_after_status");

    // Byte with download inactive is ignored
    send(25'h00000, 8'h55, 8);

    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd254;
    send(25'h0, 8'h3C, 2); send(25'h1, 8'hF0, 2); send(25'h8, 8'h11, 2);
    send(25'h2, 8'h99, 2);
    bus.ioctl_index = 8'd1;
    send(25'h0, 8'h0B, 3);
    bus.ioctl_download = 1'b0;
    check("sw0", sw0, 8'h3C);
    check("sw1", sw1, 8'hF0);
    check("core_mod", core_mod, 8'h0B);

    // Reset mid-transfer discards the pending byte
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0;
    hold = 2'b11;
    q1.push_back(pk(23'h18008, 2'b01, 8'h33)); q2.push_back(pk(23'h8, 2'b01, 8'h33));
    send(25'h30010, 8'h33, 1);
    send(25'h30012, 8'h44, 2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; bus.ioctl_download = 1'b0; hold = '0;
    @(negedge clk);
    check("reset_reqs", {bus.port1_req, bus.port2_req}, 2'b00);
    check("reset_busy", {bus.port1_req ^ bus.port1_ack, bus.port2_req ^ bus.port2_ack}, 2'b00);
    check("reset_rom_loaded", rom_loaded, 1'b0);
    check("reset_core_reset", core_reset, 1'b1);
    check("reset_keeps_core_mod", core_mod, 8'h0B);
    check("reset_keeps_sw0", sw0, 8'h3C);
    repeat (15) @(negedge clk);

    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    check("qs_drained", 64'(qs.size()), 64'd0);
    check("qp_drained", 64'(qp.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
